// File: rtl/sha2_stream_core.sv
// sha2_stream_core: unified SHA-2 compression engine (SHA-224/256 and SHA-384/512/512-224/512-256).
// Chains pre-padded blocks into a running digest and returns the truncated digest.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   block_i/block_valid_i/block_ready_o/last_block_i : padded block input stream (word 0 at MSBs)
//   abort_i        : drop the message in progress, return to idle with IV reloaded
//   busy_o         : compression rounds or final add in progress
//   digest_o/digest_valid_o/digest_ready_i : truncated digest output handshake
module sha2_stream_core #(
   parameter int unsigned WordSize    = 64,
   parameter int unsigned DigestWidth = 512
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [16*WordSize-1:0]   block_i,
   input  logic                     block_valid_i,
   output logic                     block_ready_o,
   input  logic                     last_block_i,
   input  logic                     abort_i,
   output logic                     busy_o,
   output logic [DigestWidth-1:0]   digest_o,
   output logic                     digest_valid_o,
   input  logic                     digest_ready_i
);
   localparam int unsigned BlockWidth = 16 * WordSize;
   localparam int unsigned HashWidth  = 8 * WordSize;
   localparam int unsigned NumRounds  = (WordSize == 32) ? 64 : 80;

   if (!((WordSize == 32 && (DigestWidth == 224 || DigestWidth == 256)) ||
         (WordSize == 64 && (DigestWidth == 224 || DigestWidth == 256 ||
                             DigestWidth == 384 || DigestWidth == 512)))) begin : g_bad_cfg
      $error("sha2_stream_core: unsupported WordSize/DigestWidth combination");
   end

   // Sigma rotate/shift amounts
   localparam int unsigned S0R1 = (WordSize == 32) ? 2  : 28;
   localparam int unsigned S0R2 = (WordSize == 32) ? 13 : 34;
   localparam int unsigned S0R3 = (WordSize == 32) ? 22 : 39;
   localparam int unsigned S1R1 = (WordSize == 32) ? 6  : 14;
   localparam int unsigned S1R2 = (WordSize == 32) ? 11 : 18;
   localparam int unsigned S1R3 = (WordSize == 32) ? 25 : 41;
   localparam int unsigned Ls0R1 = (WordSize == 32) ? 7  : 1;
   localparam int unsigned Ls0R2 = (WordSize == 32) ? 18 : 8;
   localparam int unsigned Ls0Sh = (WordSize == 32) ? 3  : 7;
   localparam int unsigned Ls1R1 = (WordSize == 32) ? 17 : 19;
   localparam int unsigned Ls1R2 = (WordSize == 32) ? 19 : 61;
   localparam int unsigned Ls1Sh = (WordSize == 32) ? 10 : 6;

   localparam logic [255:0] Iv224 =
      256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
   localparam logic [255:0] Iv256 =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [511:0] Iv512t224 = {64'h8c3d37c819544da2, 64'h73e1996689dcd4d6,
      64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf, 64'h0f6d2b697bd44da8, 64'h77e36f7304c48942,
      64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1};
   localparam logic [511:0] Iv512t256 = {64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2,
      64'h2393b86b6f53b151, 64'h963877195940eabd, 64'h96283ee2a88effe3, 64'hbe5e1e2553863992,
      64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2};
   localparam logic [511:0] Iv384 = {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507,
      64'h9159015a3070dd17, 64'h152fecd8f70e5939, 64'h67332667ffc00b31, 64'h8eb44a8768581511,
      64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
   localparam logic [511:0] Iv512 = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
      64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
      64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
   // 32-bit IVs sit in the low half so both families index the same way
   localparam logic [511:0] IvSel =
      (WordSize == 32) ? ((DigestWidth == 224) ? {256'h0, Iv224} : {256'h0, Iv256}) :
      (DigestWidth == 224) ? Iv512t224 : (DigestWidth == 256) ? Iv512t256 :
      (DigestWidth == 384) ? Iv384 : Iv512;

   // SHA-256 constants are the upper halves of the first 64 SHA-512 constants
   localparam logic [63:0] K512 [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StRounds = 3'd1;
   localparam logic [2:0] StFinal  = 3'd2;
   localparam logic [2:0] StWait   = 3'd3;
   localparam logic [2:0] StDone   = 3'd4;

   function automatic logic [WordSize-1:0] rotr(input logic [WordSize-1:0] x,
                                                 input int unsigned n);
      return (x >> n) | (x << (WordSize - n));
   endfunction

   logic [2:0]          state_q, state_d;
   logic [6:0]          cnt_q, cnt_d;
   logic                last_q, last_d;
   logic [WordSize-1:0] h_q [8];
   logic [WordSize-1:0] h_d [8];
   logic [WordSize-1:0] v_q [8];   // working variables a..h
   logic [WordSize-1:0] v_d [8];
   logic [WordSize-1:0] w_q [16];  // w_q[0] is W[t] of the current round
   logic [WordSize-1:0] w_d [16];
   logic [WordSize-1:0] iv_w [8];
   logic [WordSize-1:0] k_t, t1, t2, w_new, big_s0, big_s1, sm_s0, sm_s1;
   logic [HashWidth-1:0] h_cat;
   logic                accept;

   always_comb begin
      for (int i = 0; i < 8; i++) iv_w[i] = IvSel[(7-i)*WordSize +: WordSize];
   end

   assign block_ready_o  = (state_q == StIdle) || (state_q == StWait);
   assign busy_o         = (state_q == StRounds) || (state_q == StFinal);
   assign digest_valid_o = (state_q == StDone);
   assign accept         = block_ready_o & block_valid_i & ~abort_i;

   assign k_t    = K512[cnt_q][63 -: WordSize];
   assign big_s0 = rotr(v_q[0], S0R1) ^ rotr(v_q[0], S0R2) ^ rotr(v_q[0], S0R3);
   assign big_s1 = rotr(v_q[4], S1R1) ^ rotr(v_q[4], S1R2) ^ rotr(v_q[4], S1R3);
   assign t1     = v_q[7] + big_s1 + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + k_t + w_q[0];
   assign t2     = big_s0 + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
   assign sm_s0  = rotr(w_q[1], Ls0R1) ^ rotr(w_q[1], Ls0R2) ^ (w_q[1] >> Ls0Sh);
   assign sm_s1  = rotr(w_q[14], Ls1R1) ^ rotr(w_q[14], Ls1R2) ^ (w_q[14] >> Ls1Sh);
   assign w_new  = sm_s1 + w_q[9] + sm_s0 + w_q[0];

   assign h_cat    = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
   assign digest_o = digest_valid_o ? DigestWidth'(h_cat >> (HashWidth - DigestWidth)) : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      h_d     = h_q;
      v_d     = v_q;
      w_d     = w_q;
      if (abort_i) begin
         state_d = StIdle;
         cnt_d   = '0;
         h_d     = iv_w;
         v_d     = iv_w;
      end else begin
         case (state_q)
            StIdle, StWait: begin
               if (accept) begin
                  for (int i = 0; i < 16; i++) begin
                     w_d[i] = block_i[BlockWidth-1 - i*WordSize -: WordSize];
                  end
                  last_d  = last_block_i;
                  cnt_d   = '0;
                  state_d = StRounds;
               end
            end
            StRounds: begin
               v_d[0] = t1 + t2;
               v_d[1] = v_q[0];
               v_d[2] = v_q[1];
               v_d[3] = v_q[2];
               v_d[4] = v_q[3] + t1;
               v_d[5] = v_q[4];
               v_d[6] = v_q[5];
               v_d[7] = v_q[6];
               for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
               w_d[15] = w_new;
               cnt_d   = cnt_q + 7'd1;
               if (cnt_q == 7'(NumRounds - 1)) state_d = StFinal;
            end
            StFinal: begin
               for (int i = 0; i < 8; i++) begin
                  h_d[i] = h_q[i] + v_q[i];
                  v_d[i] = h_q[i] + v_q[i];
               end
               state_d = last_q ? StDone : StWait;
            end
            StDone: begin
               if (digest_ready_i) begin
                  state_d = StIdle;
                  h_d     = iv_w;
                  v_d     = iv_w;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         h_q     <= iv_w;
         v_q     <= iv_w;
         w_q     <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         h_q     <= h_d;
         v_q     <= v_d;
         w_q     <= w_d;
      end
   end

endmodule

// File: tb/tb_sha2_stream_core.sv
// Testbench for sha2_stream_core: one SHA-256 instance plus four 64-bit-word variants
// sharing one stimulus stream. Expected digests are queued at stimulus time and compared
// when the digest handshake completes.
module tb_sha2_stream_core;
   localparam logic [255:0] D256Abc =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D256TwoBlk =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [511:0] D512Abc = {256'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a,
                                      256'h2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f};
   localparam logic [383:0] D384Abc = {192'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded163,
                                      192'h1a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7};
   localparam logic [223:0] D512t224Abc =
      224'h4634270f707b6a54daae7530460842e20e37ed265ceee9a43e8924aa;
   localparam logic [255:0] D512t256Abc =
      256'h53048e2681941ef99b2e29b76b4c7dabe4c2d0c634fc6d46e0e2f13107e7af23;

   typedef struct {
      logic [511:0] d512;
      logic [383:0] d384;
      logic [223:0] d224;
      logic [255:0] d256;
   } exp64_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic [511:0]  blk32;
   logic          v32, last32, abort32, dready32;
   logic          rdy32, busy32, dval32;
   logic [255:0]  dig32;
   logic [1023:0] blk64;
   logic          v64, last64, abort64, dready64;
   logic          rdy64 [4];
   logic          busy64 [4];
   logic          dval64 [4];
   logic [511:0]  dig512;
   logic [383:0]  dig384;
   logic [223:0]  dig224;
   logic [255:0]  dig256w;

   logic [511:0]  abc32, blk_a, blk_b;
   logic [1023:0] abc64;
   logic [255:0]  exp32_q [$];
   exp64_t        exp64_q [$];
   int            n_checks = 0;
   int            n_pass = 0;

   sha2_stream_core #(.WordSize(32), .DigestWidth(256)) u_d256 (
      .clk_i(clk), .rst_i(rst), .block_i(blk32), .block_valid_i(v32), .block_ready_o(rdy32),
      .last_block_i(last32), .abort_i(abort32), .busy_o(busy32), .digest_o(dig32),
      .digest_valid_o(dval32), .digest_ready_i(dready32));
   sha2_stream_core #(.WordSize(64), .DigestWidth(512)) u_d512 (
      .clk_i(clk), .rst_i(rst), .block_i(blk64), .block_valid_i(v64), .block_ready_o(rdy64[0]),
      .last_block_i(last64), .abort_i(abort64), .busy_o(busy64[0]), .digest_o(dig512),
      .digest_valid_o(dval64[0]), .digest_ready_i(dready64));
   sha2_stream_core #(.WordSize(64), .DigestWidth(384)) u_d384 (
      .clk_i(clk), .rst_i(rst), .block_i(blk64), .block_valid_i(v64), .block_ready_o(rdy64[1]),
      .last_block_i(last64), .abort_i(abort64), .busy_o(busy64[1]), .digest_o(dig384),
      .digest_valid_o(dval64[1]), .digest_ready_i(dready64));
   sha2_stream_core #(.WordSize(64), .DigestWidth(224)) u_d224 (
      .clk_i(clk), .rst_i(rst), .block_i(blk64), .block_valid_i(v64), .block_ready_o(rdy64[2]),
      .last_block_i(last64), .abort_i(abort64), .busy_o(busy64[2]), .digest_o(dig224),
      .digest_valid_o(dval64[2]), .digest_ready_i(dready64));
   sha2_stream_core #(.WordSize(64), .DigestWidth(256)) u_d256w (
      .clk_i(clk), .rst_i(rst), .block_i(blk64), .block_valid_i(v64), .block_ready_o(rdy64[3]),
      .last_block_i(last64), .abort_i(abort64), .busy_o(busy64[3]), .digest_o(dig256w),
      .digest_valid_o(dval64[3]), .digest_ready_i(dready64));

   task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // Scoreboard compare at each digest transfer
   always @(negedge clk) begin
      if (!rst && dval32 && dready32) begin
         if (exp32_q.size() == 0) check("sb32_unexpected_digest", 512'(dval32), 512'(0));
         else check("digest32", 512'(dig32), 512'(exp32_q.pop_front()));
      end
      if (!rst && dval64[0] && dready64) begin
         if (exp64_q.size() == 0) begin
            check("sb64_unexpected_digest", 512'(dval64[0]), 512'(0));
         end else begin
            exp64_t e;
            e = exp64_q.pop_front();
            check("digest_sha512", dig512, e.d512);
            check("digest_sha384", 512'(dig384), 512'(e.d384));
            check("digest_sha512_224", 512'(dig224), 512'(e.d224));
            check("digest_sha512_256", 512'(dig256w), 512'(e.d256));
         end
      end
   end

   task automatic send32(input logic [511:0] b, input logic l);
      @(negedge clk);
      blk32 = b; last32 = l; v32 = 1'b1;
      for (int i = 0; i < 300 && !rdy32; i++) @(negedge clk);
      if (!rdy32) check("send32_ready_timeout", 512'(rdy32), 512'(1));
      @(posedge clk);
      #1;
      v32 = 1'b0; last32 = 1'b0;
   endtask

   task automatic send64(input logic [1023:0] b, input logic l);
      @(negedge clk);
      blk64 = b; last64 = l; v64 = 1'b1;
      for (int i = 0; i < 300 && !rdy64[0]; i++) @(negedge clk);
      if (!rdy64[0]) check("send64_ready_timeout", 512'(rdy64[0]), 512'(1));
      @(posedge clk);
      #1;
      v64 = 1'b0; last64 = 1'b0;
   endtask

   // Called #1 after the handshake edge (cycle 1); returns the cycle the event is first seen
   // 0: digest_valid (32), 1: block_ready (32), 2: digest_valid (64)
   task automatic wait_evt(input int sel, output int cyc, output int fb, output int lb);
      logic hit, bsy;
      cyc = 1; fb = 0; lb = 0; hit = 1'b0;
      for (int k = 0; k < 300; k++) begin
         hit = (sel == 0) ? dval32 : (sel == 1) ? rdy32 : dval64[0];
         bsy = (sel == 2) ? busy64[0] : busy32;
         if (bsy) begin
            if (fb == 0) fb = cyc;
            lb = cyc;
         end
         if (hit) break;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!hit) check("wait_event_timeout", 512'(hit), 512'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, fb, lb;
      logic seen;
      exp64_t e;
      abc32 = '0; abc32[511:480] = 32'h61626380; abc32[31:0] = 32'h18;
      abc64 = '0; abc64[1023:960] = 64'h6162638000000000; abc64[63:0] = 64'h18;
      blk_a = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
               32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
               32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0};
      blk_b = '0; blk_b[31:0] = 32'h1c0;
      rst = 1'b1;
      blk32 = '0; v32 = 0; last32 = 0; abort32 = 0; dready32 = 1;
      blk64 = '0; v64 = 0; last64 = 0; abort64 = 0; dready64 = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready32", 512'(rdy32), 512'(1));
      check("rst_busy32", 512'(busy32), 512'(0));
      check("rst_dvalid32", 512'(dval32), 512'(0));
      check("rst_digest32", 512'(dig32), 512'(0));
      check("rst_ready64", 512'(rdy64[0]), 512'(1));
      check("rst_digest64", dig512, 512'(0));
      rst = 1'b0;

      // Single-block SHA-256 "abc" with latency and busy window
      exp32_q.push_back(D256Abc);
      send32(abc32, 1'b1);
      wait_evt(0, cyc, fb, lb);
      check("t1_latency", 512'(cyc), 512'(66));
      check("t1_busy_first", 512'(fb), 512'(1));
      check("t1_busy_last", 512'(lb), 512'(65));
      @(posedge clk);
      #1;
      check("t1_ready_after", 512'(rdy32), 512'(1));

      // Two-block message with a gap between blocks
      send32(blk_a, 1'b0);
      wait_evt(1, cyc, fb, lb);
      check("t3_ready_return", 512'(cyc), 512'(66));
      check("t3_busy_last", 512'(lb), 512'(65));
      repeat (5) begin
         @(negedge clk);
         check("t3_gap_ready", 512'(rdy32), 512'(1));
         check("t3_gap_dvalid", 512'(dval32), 512'(0));
      end
      exp32_q.push_back(D256TwoBlk);
      send32(blk_b, 1'b1);
      wait_evt(0, cyc, fb, lb);
      check("t3_latency", 512'(cyc), 512'(66));
      @(posedge clk);
      #1;

      // Abort at round 30 with a block offered in the same cycle
      send32(abc32, 1'b1);
      repeat (30) @(posedge clk);
      @(negedge clk);
      abort32 = 1'b1; v32 = 1'b1; blk32 = abc32; last32 = 1'b1;
      @(posedge clk);
      #1;
      abort32 = 1'b0; v32 = 1'b0; last32 = 1'b0;
      check("t4_abort_ready", 512'(rdy32), 512'(1));
      check("t4_abort_busy", 512'(busy32), 512'(0));
      check("t4_abort_dvalid", 512'(dval32), 512'(0));
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (dval32 || busy32) seen = 1'b1;
      end
      check("t4_idle_after_abort", 512'(seen), 512'(0));
      exp32_q.push_back(D256Abc);
      send32(abc32, 1'b1);
      wait_evt(0, cyc, fb, lb);
      check("t4_rerun_latency", 512'(cyc), 512'(66));
      @(posedge clk);
      #1;

      // Digest backpressure
      dready32 = 1'b0;
      exp32_q.push_back(D256Abc);
      send32(abc32, 1'b1);
      wait_evt(0, cyc, fb, lb);
      check("t5_latency", 512'(cyc), 512'(66));
      repeat (10) begin
         @(negedge clk);
         check("t5_hold_digest", 512'(dig32), 512'(D256Abc));
         check("t5_hold_dvalid", 512'(dval32), 512'(1));
         check("t5_hold_ready", 512'(rdy32), 512'(0));
      end
      @(posedge clk);
      #1;
      dready32 = 1'b1;
      @(posedge clk);
      #1;
      check("t5_release_ready", 512'(rdy32), 512'(1));
      check("t5_release_dvalid", 512'(dval32), 512'(0));

      // 64-bit word variants on "abc"
      e.d512 = D512Abc; e.d384 = D384Abc; e.d224 = D512t224Abc; e.d256 = D512t256Abc;
      exp64_q.push_back(e);
      send64(abc64, 1'b1);
      wait_evt(2, cyc, fb, lb);
      check("t2_latency64", 512'(cyc), 512'(82));
      check("t2_busy_last64", 512'(lb), 512'(81));
      @(posedge clk);
      #1;
      check("t2_ready_after64", 512'(rdy64[0]), 512'(1));

      repeat (3) @(posedge clk);
      check("sb32_drained", 512'(exp32_q.size()), 512'(0));
      check("sb64_drained", 512'(exp64_q.size()), 512'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
